fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
// - Shares one instance of the team's combinational single-precision adder core (mainmodule) among NREQ requesters.
// - Round-robin arbitration, valid/ready handshakes on both sides, two-stage registered pipeline around the adder.
// - Each result carries the requester ID. Sits between client units and the adder.
// PARAMETERS
// NREQ   4   number of requesters, 2..8
// IDW    $clog2(NREQ)   width of requester ID (derived, not overridden)
// PORTS
// clk         in   1         single clock, rising edge
// rst_n       in   1         asynchronous active-low reset
// req_valid   in   NREQ      per-requester operation valid
// req_ready   out  NREQ      per-requester accept; at most one bit high per cycle
// req_a       in   NREQ*32   operand A per requester, IEEE-754 single; slice i = [32*i+31:32*i]
// req_b       in   NREQ*32   operand B per requester, same packing
// rsp_valid   out  1         result valid
// rsp_ready   in   1         downstream accepts result
// rsp_res     out  32        a+b from the adder core
// rsp_id      out  IDW       index of the requester that issued the op
// busy        out  1         any pipeline stage occupied
// BEHAVIOUR
// - Reset (async, rst_n=0): s1_valid=0, rsp_valid=0, rr_ptr=0, busy=0, req_ready=0, rsp_res=0, rsp_id=0.
// - Transfer rule: a transfer occurs on a rising edge where valid&&ready. A requester holds valid and operands stable until accepted.
// - Stage 1 (S1): on accept, registers a, b and id; sets s1_valid. The adder core is combinational from the S1 regs.
// - Stage 2 (OUT): registers adder res and S1 id into rsp_res/rsp_id; sets rsp_valid.
// - Advance conditions:
//   - adv2 = s1_valid && (!rsp_valid || rsp_ready).
//   - adv1 = !s1_valid || adv2.
// - Latency: accept at edge T -> rsp_valid high after edge T+1 when not stalled. Throughput is 1 op/cycle with rsp_ready tied high.
// - Backpressure: when rsp_valid=1 and rsp_ready=0, OUT holds and rsp_res/rsp_id stay stable.
//   - S1 holds if also full; all req_ready=0 while adv1=0.
//   - rsp_valid drops after a consumed result only if adv2=0.
// - Arbitration:
//   - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   - req_ready[grant] = adv1 and is combinational; req_ready may depend on req_valid.
//   - On accept, rr_ptr <= (grant+1) mod NREQ. With no accept, rr_ptr holds.
// - Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 accepts.
// - Ordering: results leave in accept order. No reordering, no dropping.
// - Simultaneous events:
//   - OUT consumed and S1 advanced in the same cycle: new result loaded, rsp_valid stays 1.
//   - S1 advanced and a new accept in the same cycle: S1 reloads, s1_valid stays 1.
// - busy = s1_valid || rsp_valid.
// - Reset mid-operation: in-flight ops are discarded with no response. After deassert, arbitration restarts at requester 0.
// - Arithmetic: no width changes and no exception handling here. Result bits are exactly the adder core output for the S1 operands.
// STRUCTURE
// - Package fpadd_pkg:
//   - typedef logic [31:0] float32_t.
//   - constant FP_NREQ_DEF=4.
//   - function id_width(n).
//   - float constants for the bench: FP_ONE=32'h3F80_0000, FP_TWO=32'h4000_0000.
// - Sub-module rr_arbiter #(N):
//   - inputs: clk, rst_n, req[N], advance.
//   - outputs: one-hot gnt[N], gnt_idx.
//   - owns rr_ptr; pointer updates only when advance && |req.
// - Top level: rr_arbiter, operand mux, S1/OUT registers, one mainmodule instance (res wired to the OUT register input).
// TESTING
// - Single op: req0 a=3F800000 b=40000000, rsp_ready=1.
//   -> accepted in the cycle offered; rsp_valid 2 edges later; res=40400000, id=0.
// - Signed cancel: req2 a=3FC00000 b=BF000000.
//   -> res=3F800000, id=2. Also 40400000+C0400000 -> 00000000.
// - Round-robin: all 4 valid continuously, each with distinct operands, rsp_ready=1.
//   -> ids 0,1,2,3,0,...; one accept per cycle.
// - Backpressure: rsp_ready=0 for 5 cycles with 3 requesters valid.
//   -> two ops held (S1+OUT); all req_ready=0; rsp_res stable.
//   -> on release, no loss and order preserved.
// - Reset mid-flight: rst_n low with S1 and OUT full.
//   -> rsp_valid=0 and busy=0 immediately; after release, first grant goes to lowest valid index from 0.
// - Sparse traffic: only req3 valid, then req1 next cycle.
//   -> grants 3 then 1; rr_ptr wraps to 0 after grant 3.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared types and constants for the shared FP-adder arbiter slice.
package fpadd_pkg;
   typedef logic [31:0] float32_t;

   localparam int unsigned FP_NREQ_DEF = 4;
   localparam float32_t    FP_ONE      = 32'h3F80_0000;
   localparam float32_t    FP_TWO      = 32'h4000_0000;

   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/mainmodule.sv
// Combinational IEEE-754 single-precision adder core, round-to-nearest-even.
module mainmodule (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res
);
   logic [31:0] x, y;
   logic [7:0]  ex, ey, diff;
   logic [26:0] ax, ay_full, ay, m;
   logic [27:0] sum;
   logic [9:0]  e;
   logic [24:0] mant;
   logic        sub, inc;

   always_comb begin
      // x always carries the larger magnitude, so the result sign is x's sign
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      ex      = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey      = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      diff    = ex - ey;
      sub     = x[31] ^ y[31];
      ax      = {|x[30:23], x[22:0], 3'b000};
      ay_full = {|y[30:23], y[22:0], 3'b000};
      if (diff > 8'd26) begin
         ay = {26'd0, |ay_full};
      end else begin
         ay    = ay_full >> diff;
         ay[0] = ay[0] | (|(ay_full & ~({27{1'b1}} << diff)));
      end
      sum = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
      e   = {2'b00, ex};
      if (sum[27]) begin
         m = sum[27:1] | {26'd0, sum[0]};
         e = e + 10'd1;
      end else begin
         m = sum[26:0];
      end
      for (int unsigned i = 0; i < 26; i++) begin
         if (!m[26] && (e > 10'd1)) begin
            m = m << 1;
            e = e - 10'd1;
         end
      end
      inc  = m[2] & (m[1] | m[0] | m[3]);
      mant = {1'b0, m[26:3]} + {24'd0, inc};
      if (mant[24]) begin
         mant = mant >> 1;
         e    = e + 10'd1;
      end
      if (x[30:23] == 8'hFF)
         res = ((x[22:0] != 23'd0) || ((y[30:23] == 8'hFF) && sub)) ? 32'h7FC0_0000 : x;
      else if (sum == 28'd0)
         res = {x[31] & y[31], 31'd0};
      else if (e >= 10'd255)
         res = {x[31], 8'hFF, 23'd0};
      else
         res = {x[31], (mant[23] ? e[7:0] : 8'd0), mant[22:0]};
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from rr_ptr, pointer moves past each grant taken.
module rr_arbiter
   import fpadd_pkg::*;
#(
   parameter  int unsigned N  = FP_NREQ_DEF,
   localparam int unsigned IW = id_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   logic [IW-1:0] rr_ptr;
   logic          found;
   int unsigned   j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (int'(rr_ptr) + k) % N;
         if (!found && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (advance && (|req))
         rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
   end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one combinational FP adder among NREQ requesters: round-robin grant, S1 operand stage, OUT result stage.
module fp_add_arbiter
   import fpadd_pkg::*;
#(
   parameter  int unsigned NREQ = FP_NREQ_DEF,
   localparam int unsigned IDW  = id_width(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output float32_t           rsp_res,
   output logic [IDW-1:0]     rsp_id,
   output logic               busy
);
   logic           s1_valid, adv1, adv2, accept;
   float32_t       s1_a, s1_b, sel_a, sel_b, sum;
   logic [IDW-1:0] s1_id, gnt_idx;
   logic [NREQ-1:0] gnt;

   assign adv2      = s1_valid && (!rsp_valid || rsp_ready);
   assign adv1      = !s1_valid || adv2;
   assign accept    = adv1 && (|req_valid);
   // ready is gated by rst_n so nothing looks accepted while reset is held
   assign req_ready = (adv1 && rst_n) ? gnt : '0;
   assign busy      = s1_valid || rsp_valid;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (adv1),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
      end else if (adv1) begin
         s1_valid <= |req_valid;
         if (accept) begin
            s1_a  <= sel_a;
            s1_b  <= sel_b;
            s1_id <= gnt_idx;
         end
      end
   end

   mainmodule u_add (
      .a   (s1_a),
      .b   (s1_b),
      .res (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_res   <= '0;
         rsp_id    <= '0;
      end else if (adv2) begin
         rsp_valid <= 1'b1;
         rsp_res   <= sum;
         rsp_id    <= s1_id;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: single ops, cancel, sparse, reset mid-flight, round-robin, backpressure.
module tb_fp_add_arbiter;
   import fpadd_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid, req_ready;
   logic [127:0] req_a, req_b;
   logic         rsp_valid, rsp_ready, busy;
   float32_t     rsp_res;
   logic [1:0]   rsp_id;

   float32_t a_r [4];
   float32_t b_r [4];
   float32_t rr_exp [4];

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_a[32*i +: 32] = a_r[i];
         req_b[32*i +: 32] = b_r[i];
      end
   end

   fp_add_arbiter #(.NREQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic single_op(input int unsigned id, input float32_t a, input float32_t b,
                            input float32_t exp_res);
      logic [3:0] onehot;
      onehot     = '0;
      onehot[id] = 1'b1;
      a_r[id]    = a;
      b_r[id]    = b;
      req_valid  = onehot;
      @(negedge clk);
      check("single_ready", 64'(req_ready), 64'(onehot));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("single_s1_rsp_valid", 64'(rsp_valid), 64'h0);
      check("single_s1_busy", 64'(busy), 64'h1);
      @(posedge clk);
      @(negedge clk);
      check("single_rsp_valid", 64'(rsp_valid), 64'h1);
      check("single_rsp_res", 64'(rsp_res), 64'(exp_res));
      check("single_rsp_id", 64'(rsp_id), 64'(id));
      @(posedge clk);
      @(negedge clk);
      check("single_drain_valid", 64'(rsp_valid), 64'h0);
      check("single_drain_busy", 64'(busy), 64'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_rdy;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_r[i] = '0;
         b_r[i] = '0;
      end
      rr_exp[0] = 32'h4000_0000;
      rr_exp[1] = 32'h4040_0000;
      rr_exp[2] = 32'h4080_0000;
      rr_exp[3] = 32'h40C0_0000;

      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_rsp_res", 64'(rsp_res), 64'h0);
      check("rst_rsp_id", 64'(rsp_id), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1.0 + 2.0 on requester 0; pointer moves to 1
      single_op(0, FP_ONE, FP_TWO, 32'h4040_0000);
      // 1.5 + -0.5 on requester 2; pointer moves to 3
      single_op(2, 32'h3FC0_0000, 32'hBF00_0000, FP_ONE);
      single_op(2, 32'h4040_0000, 32'hC040_0000, 32'h0000_0000);

      // sparse: requester 3 then requester 1
      a_r[3] = FP_TWO; b_r[3] = FP_TWO;
      a_r[1] = FP_ONE; b_r[1] = FP_ONE;
      req_valid = 4'b1000;
      @(negedge clk);
      check("sparse_ready3", 64'(req_ready), 64'h8);
      @(posedge clk); #1;
      req_valid = 4'b0010;
      @(negedge clk);
      check("sparse_ready1", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("sparse_rsp_id3", 64'(rsp_id), 64'h3);
      check("sparse_rsp_res3", 64'(rsp_res), 64'h4080_0000);
      @(posedge clk);
      @(negedge clk);
      check("sparse_rsp_id1", 64'(rsp_id), 64'h1);
      check("sparse_rsp_res1", 64'(rsp_res), 64'h4000_0000);
      @(posedge clk);
      @(negedge clk);
      check("sparse_drain", 64'(rsp_valid), 64'h0);
      @(posedge clk); #1;

      // round-robin operand table: 1+1, 1+2, 2+2, 3+3
      a_r[0] = FP_ONE;        b_r[0] = FP_ONE;
      a_r[1] = FP_ONE;        b_r[1] = FP_TWO;
      a_r[2] = FP_TWO;        b_r[2] = FP_TWO;
      a_r[3] = 32'h4040_0000; b_r[3] = 32'h4040_0000;

      // reset with S1 and OUT both full (pointer is 2 here)
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      @(negedge clk);
      check("mid_ready2", 64'(req_ready), 64'h4);
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_ready3", 64'(req_ready), 64'h8);
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_full_ready", 64'(req_ready), 64'h0);
      check("mid_full_valid", 64'(rsp_valid), 64'h1);
      check("mid_full_id", 64'(rsp_id), 64'h2);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(rsp_valid), 64'h0);
      check("mid_rst_busy", 64'(busy), 64'h0);
      check("mid_rst_ready", 64'(req_ready), 64'h0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      // all four valid: grants rotate from 0, one per cycle, results two cycles behind
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c < 8) begin
            exp_rdy = 4'(1 << (c % 4));
            check("rr_ready", 64'(req_ready), 64'(exp_rdy));
         end
         if (c >= 2) begin
            check("rr_rsp_valid", 64'(rsp_valid), 64'h1);
            check("rr_rsp_id", 64'(rsp_id), 64'((c - 2) % 4));
            check("rr_rsp_res", 64'(rsp_res), 64'(rr_exp[(c - 2) % 4]));
         end
         @(posedge clk); #1;
         if (c == 7) req_valid = '0;
      end
      @(negedge clk);
      check("rr_drain_busy", 64'(busy), 64'h0);
      @(posedge clk); #1;

      // backpressure: three requesters, downstream stalled (pointer is 0 here)
      rsp_ready = 1'b0;
      req_valid = 4'b0111;
      @(negedge clk);
      check("bp_ready0", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_ready1", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check("bp_stall_ready", 64'(req_ready), 64'h0);
         check("bp_stall_valid", 64'(rsp_valid), 64'h1);
         check("bp_stall_id", 64'(rsp_id), 64'h0);
         check("bp_stall_res", 64'(rsp_res), 64'h4000_0000);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_ready2", 64'(req_ready), 64'h4);
      check("bp_rel_id0", 64'(rsp_id), 64'h0);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("bp_rel_valid1", 64'(rsp_valid), 64'h1);
      check("bp_rel_id1", 64'(rsp_id), 64'h1);
      check("bp_rel_res1", 64'(rsp_res), 64'h4040_0000);
      @(posedge clk);
      @(negedge clk);
      check("bp_rel_id2", 64'(rsp_id), 64'h2);
      check("bp_rel_res2", 64'(rsp_res), 64'h4080_0000);
      @(posedge clk);
      @(negedge clk);
      check("bp_end_valid", 64'(rsp_valid), 64'h0);
      check("bp_end_busy", 64'(busy), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
